data_sram_responder: RTL

//  Responder end of the CPU data-SRAM port driven by the execute stage (en/wen/addr/wdata).

---
 rtl/data_sram_responder.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Responder end of the CPU data-SRAM port. The execute stage issues at most one
// request per cycle on en/wen/addr/wdata. This block holds a word-organised
// data RAM with byte-masked writes. Read data returns after a fixed latency of
// READ_LAT cycles.
//
// Accesses that fall outside the address window raise a one-cycle addr_err
// pulse, aligned with the slot in which read data would have appeared.
// Accepted reads and writes are tallied in saturating counters.
//
// Parameters
//   BASE_ADDR  byte address of word 0 (4-byte aligned)
//   DEPTH      number of 32-bit words (power of two, >= 2)
//   READ_LAT   request-to-data latency in cycles (1..4)
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            asynchronous, active-high reset
//   data_sram_en     request strobe
//   data_sram_wen    byte write enables, 4'h0 means read
//   data_sram_addr   byte address, bits [1:0] ignored for indexing
//   data_sram_wdata  write data, byte i = wdata[8i+7:8i]
//   data_sram_rdata  read data, holds its last value while rdata_valid=0
//   rdata_valid      one-cycle pulse per completed read
//   addr_err         one-cycle pulse for an out-of-window access
//   rd_count         reads accepted (in window), saturating
//   wr_count         writes accepted (in window), saturating
//
// The RAM itself is never reset: its contents survive a reset. Only the
// latency pipe, the output registers and the counters are cleared.
// -----------------------------------------------------------------------------
module data_sram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 16384,
    parameter int          READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Replace only the bytes selected by mask; all other bytes keep their old value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Storage and pipeline state
    logic [31:0] mem_q [DEPTH];
    logic        vld_q [READ_LAT];
    logic        err_q [READ_LAT];
    logic [31:0] dat_q [READ_LAT];
    logic [31:0] rd_count_q;
    logic [31:0] wr_count_q;

    // Decoded request and next-state values
    logic [31:0]   word_off_s;
    logic          hit_s;
    logic [AW-1:0] idx_s;
    logic          rd_req_s;
    logic          wr_req_s;
    logic          vld0_d;
    logic          err0_d;
    logic [31:0]   dat0_d;
    logic [31:0]   rd_count_d;
    logic [31:0]   wr_count_d;

    // Address window decode.
    // BASE_ADDR is word aligned, so the 32-bit byte difference shifted right by
    // two equals the 30-bit word difference with modular wrap. That keeps
    // addresses just below BASE_ADDR, or near the top of the space, from
    // aliasing into the window.
    always_comb begin
        word_off_s = (data_sram_addr - BASE_ADDR) >> 32'd2;
        hit_s      = (word_off_s < DEPTH_W);
        idx_s      = word_off_s[AW-1:0];
        rd_req_s   = data_sram_en & (data_sram_wen == 4'h0);
        wr_req_s   = data_sram_en & (data_sram_wen != 4'h0);
    end

    // First latency stage.
    // The RAM word is sampled at the request edge, so only writes from earlier
    // edges are visible to it.
    always_comb begin
        vld0_d = rd_req_s;
        err0_d = data_sram_en & ~hit_s;
        dat0_d = 32'h0;
        if (rd_req_s && hit_s) begin
            dat0_d = mem_q[idx_s];
        end else begin
            dat0_d = 32'h0;
        end
    end

    // Saturating access counters; only in-window accesses are counted.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_req_s && hit_s && (rd_count_q != CNT_MAX)) begin
            rd_count_d = rd_count_q + 32'd1;
        end else begin
            rd_count_d = rd_count_q;
        end
        if (wr_req_s && hit_s && (wr_count_q != CNT_MAX)) begin
            wr_count_d = wr_count_q + 32'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // RAM write port: byte-masked, no reset so contents persist across reset.
    always_ff @(posedge clk) begin
        if (wr_req_s && hit_s) begin
            mem_q[idx_s] <= merge_bytes(mem_q[idx_s], data_sram_wdata, data_sram_wen);
        end
    end

    // Latency pipe.
    // A data stage only loads when a valid read enters it. That way the last
    // stage, which drives rdata, holds the most recent read result between
    // pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < READ_LAT; k++) begin
                vld_q[k] <= 1'b0;
                err_q[k] <= 1'b0;
                dat_q[k] <= 32'h0;
            end
        end else begin
            vld_q[0] <= vld0_d;
            err_q[0] <= err0_d;
            if (vld0_d) begin
                dat_q[0] <= dat0_d;
            end
            for (int k = 1; k < READ_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                err_q[k] <= err_q[k-1];
                if (vld_q[k-1]) begin
                    dat_q[k] <= dat_q[k-1];
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= 32'h0;
            wr_count_q <= 32'h0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign data_sram_rdata = dat_q[READ_LAT-1];
    assign rdata_valid     = vld_q[READ_LAT-1];
    assign addr_err        = err_q[READ_LAT-1];
    assign rd_count        = rd_count_q;
    assign wr_count        = wr_count_q;

endmodule
